// File: rtl/perceptron_train_queue.sv
// In-order branch training queue: records predictions at issue, accepts out-of-order
// resolutions, and retires entries in program order as one-cycle training pulses.
module perceptron_train_queue #(
    parameter int DEPTH     = 8,
    parameter int TAG_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_valid,
    input  logic [31:0]          alloc_pc,
    input  logic                 alloc_pred,
    output logic                 alloc_ready,
    output logic [TAG_WIDTH-1:0] alloc_tag,
    input  logic                 resolve_valid,
    input  logic [TAG_WIDTH-1:0] resolve_tag,
    input  logic                 resolve_taken,
    input  logic                 flush,
    output logic                 train_en,
    output logic [31:0]          train_pc,
    output logic                 actual_taken,
    output logic                 history_update_en,
    output logic                 branch_taken,
    output logic                 mispredict,
    output logic                 resolve_err,
    output logic [TAG_WIDTH:0]   occupancy
);

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        PENDING  = 2'd1,
        RESOLVED = 2'd2
    } entry_state_t;

    localparam logic [TAG_WIDTH:0]   FULL_CNT = (TAG_WIDTH + 1)'(DEPTH);
    localparam logic [TAG_WIDTH-1:0] TAG_ONE  = TAG_WIDTH'(1);

    entry_state_t         state   [DEPTH];
    logic [31:0]          pc_mem  [DEPTH];
    logic                 pred_mem[DEPTH];
    logic                 taken_mem[DEPTH];

    logic [TAG_WIDTH-1:0] head;
    logic [TAG_WIDTH-1:0] tail;
    logic [TAG_WIDTH:0]   count;

    logic full;
    logic alloc_fire_p0;
    logic resolve_ok_p0;
    logic resolve_bad_p0;
    logic retire_p0;

    always_comb begin
        full        = (count == FULL_CNT);
        alloc_ready = !full && !flush;
        alloc_tag   = tail;
        occupancy   = count;

        alloc_fire_p0  = alloc_valid && alloc_ready;
        // The tail slot is FREE whenever an alloc can fire, so a same-cycle resolve
        // of the allocating tag naturally falls into the illegal case.
        resolve_ok_p0  = resolve_valid && !flush && (state[resolve_tag] == PENDING);
        resolve_bad_p0 = resolve_valid && !flush && (state[resolve_tag] != PENDING);
        retire_p0      = (state[head] == RESOLVED);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                state[i] <= FREE;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (retire_p0) begin
                state[head] <= FREE;
                head        <= head + TAG_ONE;
            end
            if (resolve_ok_p0) begin
                state[resolve_tag] <= RESOLVED;
            end
            if (alloc_fire_p0) begin
                state[tail] <= PENDING;
                tail        <= tail + TAG_ONE;
            end
            case ({alloc_fire_p0, retire_p0})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry payload carries no reset; validity is tracked by state alone.
    always_ff @(posedge clk) begin
        if (alloc_fire_p0) begin
            pc_mem[tail]   <= alloc_pc;
            pred_mem[tail] <= alloc_pred;
        end
        if (resolve_ok_p0) begin
            taken_mem[resolve_tag] <= resolve_taken;
        end
    end

    // ---- stage p1: registered training pulse (survives a same-cycle flush) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            train_en     <= 1'b0;
            train_pc     <= '0;
            actual_taken <= 1'b0;
            mispredict   <= 1'b0;
            resolve_err  <= 1'b0;
        end else begin
            train_en     <= retire_p0;
            train_pc     <= retire_p0 ? pc_mem[head] : 32'd0;
            actual_taken <= retire_p0 && taken_mem[head];
            mispredict   <= retire_p0 && (taken_mem[head] != pred_mem[head]);
            if (resolve_bad_p0) begin
                resolve_err <= 1'b1;
            end
        end
    end

    assign history_update_en = train_en;
    assign branch_taken      = actual_taken;

endmodule

// File: tb/tb_perceptron_train_queue.sv
// Directed table-driven bench for perceptron_train_queue (DEPTH=8): one row per cycle,
// inputs driven at the falling edge and outputs compared shortly after.
module tb_perceptron_train_queue;

    logic        clk;
    logic        rst;
    logic        alloc_valid;
    logic [31:0] alloc_pc;
    logic        alloc_pred;
    logic        alloc_ready;
    logic [2:0]  alloc_tag;
    logic        resolve_valid;
    logic [2:0]  resolve_tag;
    logic        resolve_taken;
    logic        flush;
    logic        train_en;
    logic [31:0] train_pc;
    logic        actual_taken;
    logic        history_update_en;
    logic        branch_taken;
    logic        mispredict;
    logic        resolve_err;
    logic [3:0]  occupancy;

    perceptron_train_queue #(.DEPTH(8), .TAG_WIDTH(3)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_pred(alloc_pred),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .resolve_valid(resolve_valid), .resolve_tag(resolve_tag), .resolve_taken(resolve_taken),
        .flush(flush),
        .train_en(train_en), .train_pc(train_pc), .actual_taken(actual_taken),
        .history_update_en(history_update_en), .branch_taken(branch_taken),
        .mispredict(mispredict), .resolve_err(resolve_err), .occupancy(occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        r;
        logic        av;
        logic [31:0] pc;
        logic        pr;
        logic        rv;
        logic [2:0]  rt;
        logic        rk;
        logic        fl;
        logic        e_ready;
        logic [2:0]  e_tag;
        logic [3:0]  e_occ;
        logic        e_ten;
        logic [31:0] e_pc;
        logic        e_act;
        logic        e_mis;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic add(input logic r, input logic av, input logic [31:0] pc, input logic pr,
                       input logic rv, input logic [2:0] rt, input logic rk, input logic fl,
                       input logic e_ready, input logic [2:0] e_tag, input logic [3:0] e_occ,
                       input logic e_ten, input logic [31:0] e_pc, input logic e_act,
                       input logic e_mis, input logic e_err);
        vec_t v;
        v.r = r; v.av = av; v.pc = pc; v.pr = pr; v.rv = rv; v.rt = rt; v.rk = rk; v.fl = fl;
        v.e_ready = e_ready; v.e_tag = e_tag; v.e_occ = e_occ; v.e_ten = e_ten;
        v.e_pc = e_pc; v.e_act = e_act; v.e_mis = e_mis; v.e_err = e_err;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
        end
    endtask

    task automatic apply(input int row, input vec_t v);
        @(negedge clk);
        rst = v.r; alloc_valid = v.av; alloc_pc = v.pc; alloc_pred = v.pr;
        resolve_valid = v.rv; resolve_tag = v.rt; resolve_taken = v.rk; flush = v.fl;
        #1;
        n_vec++;
        chk("alloc_ready",       row, 32'(alloc_ready),       32'(v.e_ready));
        chk("alloc_tag",         row, 32'(alloc_tag),         32'(v.e_tag));
        chk("occupancy",         row, 32'(occupancy),         32'(v.e_occ));
        chk("train_en",          row, 32'(train_en),          32'(v.e_ten));
        chk("history_update_en", row, 32'(history_update_en), 32'(v.e_ten));
        chk("train_pc",          row, train_pc,               v.e_pc);
        chk("actual_taken",      row, 32'(actual_taken),      32'(v.e_act));
        chk("branch_taken",      row, 32'(branch_taken),      32'(v.e_act));
        chk("mispredict",        row, 32'(mispredict),        32'(v.e_mis));
        chk("resolve_err",       row, 32'(resolve_err),       32'(v.e_err));
    endtask

    initial begin
        int cnt;
        //  r av pc      pr rv rt rk fl | rdy tag occ ten pc     act mis err
        // single entry, mispredicted
        add(0, 1, 'h100, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0,     0, 0, 0);
        add(0, 0, 0,     0, 1, 0, 0, 0,   1, 1, 1, 0, 0,     0, 0, 0);
        add(0, 0, 0,     0, 0, 0, 0, 0,   1, 1, 1, 0, 0,     0, 0, 0);
        add(0, 0, 0,     0, 0, 0, 0, 0,   1, 1, 0, 1, 'h100, 0, 1, 0);
        add(1, 0, 0,     0, 0, 0, 0, 0,   1, 1, 0, 0, 0,     0, 0, 0);
        // three entries resolved in reverse order, retire in order
        add(0, 1, 'h200, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0,     0, 0, 0);
        add(0, 1, 'h204, 0, 0, 0, 0, 0,   1, 1, 1, 0, 0,     0, 0, 0);
        add(0, 1, 'h208, 1, 0, 0, 0, 0,   1, 2, 2, 0, 0,     0, 0, 0);
        add(0, 0, 0,     0, 1, 2, 1, 0,   1, 3, 3, 0, 0,     0, 0, 0);
        add(0, 0, 0,     0, 1, 1, 1, 0,   1, 3, 3, 0, 0,     0, 0, 0);
        add(0, 0, 0,     0, 1, 0, 1, 0,   1, 3, 3, 0, 0,     0, 0, 0);
        add(0, 0, 0,     0, 0, 0, 0, 0,   1, 3, 3, 0, 0,     0, 0, 0);
        add(0, 0, 0,     0, 0, 0, 0, 0,   1, 3, 2, 1, 'h200, 1, 0, 0);
        add(0, 0, 0,     0, 0, 0, 0, 0,   1, 3, 1, 1, 'h204, 1, 1, 0);
        add(0, 0, 0,     0, 0, 0, 0, 0,   1, 3, 0, 1, 'h208, 1, 0, 0);
        add(0, 0, 0,     0, 0, 0, 0, 0,   1, 3, 0, 0, 0,     0, 0, 0);
        // resolve of an unallocated tag: sticky error, no pulse
        add(0, 0, 0,     0, 1, 5, 1, 0,   1, 3, 0, 0, 0,     0, 0, 0);
        add(0, 0, 0,     0, 0, 0, 0, 0,   1, 3, 0, 0, 0,     0, 0, 1);
        add(0, 0, 0,     0, 0, 0, 0, 0,   1, 3, 0, 0, 0,     0, 0, 1);
        add(1, 0, 0,     0, 0, 0, 0, 0,   1, 3, 0, 0, 0,     0, 0, 1);
        // fill to full
        for (int i = 0; i < 8; i++)
            add(0, 1, 32'h300 + 32'(4 * i), i[0], 0, 0, 0, 0, 1, 3'(i), 4'(i), 0, 0, 0, 0, 0);
        add(0, 1, 'hDEAD, 0, 1, 0, 0, 0,  0, 0, 8, 0, 0,     0, 0, 0);
        add(0, 1, 'hBEEF, 0, 0, 0, 0, 0,  0, 0, 8, 0, 0,     0, 0, 0);
        add(0, 1, 'h400, 1, 0, 0, 0, 0,   1, 0, 7, 1, 'h300, 0, 0, 0);
        add(0, 0, 0,     0, 0, 0, 0, 0,   0, 1, 8, 0, 0,     0, 0, 0);
        // flush in the cycle the resolved head retires
        add(0, 0, 0,     0, 1, 1, 1, 0,   0, 1, 8, 0, 0,     0, 0, 0);
        add(0, 1, 'h999, 1, 1, 2, 1, 1,   0, 1, 8, 0, 0,     0, 0, 0);
        add(0, 0, 0,     0, 0, 0, 0, 0,   1, 0, 0, 1, 'h304, 1, 0, 0);
        add(0, 0, 0,     0, 1, 2, 0, 0,   1, 0, 0, 0, 0,     0, 0, 0);
        add(0, 0, 0,     0, 0, 0, 0, 0,   1, 0, 0, 0, 0,     0, 0, 1);
        add(1, 0, 0,     0, 0, 0, 0, 0,   1, 0, 0, 0, 0,     0, 0, 1);
        // alloc and retire in the same cycle
        add(0, 1, 'h500, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0,     0, 0, 0);
        add(0, 0, 0,     0, 1, 0, 0, 0,   1, 1, 1, 0, 0,     0, 0, 0);
        add(0, 1, 'h504, 1, 0, 0, 0, 0,   1, 1, 1, 0, 0,     0, 0, 0);
        add(0, 0, 0,     0, 0, 0, 0, 0,   1, 2, 1, 1, 'h500, 0, 0, 0);
        // reset with four resolved entries in flight
        add(0, 1, 'h600, 0, 0, 0, 0, 0,   1, 2, 1, 0, 0,     0, 0, 0);
        add(0, 1, 'h604, 0, 0, 0, 0, 0,   1, 3, 2, 0, 0,     0, 0, 0);
        add(0, 1, 'h608, 0, 0, 0, 0, 0,   1, 4, 3, 0, 0,     0, 0, 0);
        add(0, 0, 0,     0, 1, 4, 1, 0,   1, 5, 4, 0, 0,     0, 0, 0);
        add(0, 0, 0,     0, 1, 3, 1, 0,   1, 5, 4, 0, 0,     0, 0, 0);
        add(0, 0, 0,     0, 1, 2, 1, 0,   1, 5, 4, 0, 0,     0, 0, 0);
        add(0, 0, 0,     0, 1, 1, 1, 0,   1, 5, 4, 0, 0,     0, 0, 0);
        add(1, 0, 0,     0, 0, 0, 0, 0,   1, 5, 4, 0, 0,     0, 0, 0);
        add(0, 0, 0,     0, 0, 0, 0, 0,   1, 0, 0, 0, 0,     0, 0, 0);
        add(0, 0, 0,     0, 0, 0, 0, 0,   1, 0, 0, 0, 0,     0, 0, 0);

        rst = 1'b1; alloc_valid = 1'b0; alloc_pc = '0; alloc_pred = 1'b0;
        resolve_valid = 1'b0; resolve_tag = '0; resolve_taken = 1'b0; flush = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        chk("reset train_en",    -1, 32'(train_en),    0);
        chk("reset train_pc",    -1, train_pc,         0);
        chk("reset mispredict",  -1, 32'(mispredict),  0);
        chk("reset resolve_err", -1, 32'(resolve_err), 0);
        chk("reset occupancy",   -1, 32'(occupancy),   0);
        chk("reset alloc_tag",   -1, 32'(alloc_tag),   0);
        chk("reset alloc_ready", -1, 32'(alloc_ready), 1);

        foreach (vecs[i]) apply(i, vecs[i]);

        // latency: resolve of the head in cycle t gives train_en in cycle t+2
        @(negedge clk);
        alloc_valid = 1'b1; alloc_pc = 32'h700; alloc_pred = 1'b1;
        @(negedge clk);
        alloc_valid = 1'b0; resolve_valid = 1'b1; resolve_tag = 3'd0; resolve_taken = 1'b1;
        @(negedge clk);
        resolve_valid = 1'b0;
        cnt = 1;
        #1;
        while (train_en !== 1'b1 && cnt < 10) begin
            @(negedge clk);
            #1;
            cnt++;
        end
        n_vec++;
        chk("latency cycles",   -2, 32'(cnt),        2);
        chk("latency train_pc", -2, train_pc,        32'h700);
        chk("latency mispred",  -2, 32'(mispredict), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
